tl_ul_arb_2m: RTL and testbench

- Two-master TileLink-UL Channel A arbiter with Channel D response router.
- Sits between two masters and the single-slave crossbar/CDC path.
- Round-robin grant on A, held until the beat is accepted.
- Tags each request with the master index in the source field and routes D responses back by that tag.
- Per-master outstanding-request counters enforce a limit and flag unexpected responses.

---
 rtl/tl_ul_arb_2m.sv | 194 +++++++++++++++++++
 tb/tb_tl_ul_arb_2m.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_arb_2m.sv
// Two-master TileLink-UL arbiter.
// Channel A: round-robin grant between m0/m1, locked onto the presented master
//   until its beat is accepted; a_source_out = {grant index, master source}.
// Channel D: routed back to the master named by d_source_in[1]; a beat for a
//   master with no outstanding requests is consumed and flagged in err_unexp.
// Ports: clk, reset (async active-low), m0_*/m1_* master A/D channels,
//   a_*_out / a_ready_out downstream A, d_*_in / d_ready_in downstream D,
//   outst0/outst1 outstanding counts, err_unexp sticky error.
module tl_ul_arb_2m #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned PARAM_WIDTH  = 3,
  parameter int unsigned SINK_WIDTH   = 1,
  parameter int unsigned MAX_OUTST    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  // master 0 A
  input  logic                    m0_a_valid,
  output logic                    m0_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m0_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m0_a_param,
  input  logic [SIZE_WIDTH-1:0]   m0_a_size,
  input  logic [ADDR_WIDTH-1:0]   m0_a_address,
  input  logic [MASK_WIDTH-1:0]   m0_a_mask,
  input  logic [DATA_WIDTH-1:0]   m0_a_data,
  input  logic                    m0_a_source,
  // master 0 D
  output logic                    m0_d_valid,
  input  logic                    m0_d_ready,
  output logic [OPCODE_WIDTH-1:0] m0_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m0_d_param,
  output logic [SIZE_WIDTH-1:0]   m0_d_size,
  output logic [SINK_WIDTH-1:0]   m0_d_sink,
  output logic [DATA_WIDTH-1:0]   m0_d_data,
  output logic                    m0_d_error,
  output logic                    m0_d_source,
  // master 1 A
  input  logic                    m1_a_valid,
  output logic                    m1_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m1_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m1_a_param,
  input  logic [SIZE_WIDTH-1:0]   m1_a_size,
  input  logic [ADDR_WIDTH-1:0]   m1_a_address,
  input  logic [MASK_WIDTH-1:0]   m1_a_mask,
  input  logic [DATA_WIDTH-1:0]   m1_a_data,
  input  logic                    m1_a_source,
  // master 1 D
  output logic                    m1_d_valid,
  input  logic                    m1_d_ready,
  output logic [OPCODE_WIDTH-1:0] m1_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m1_d_param,
  output logic [SIZE_WIDTH-1:0]   m1_d_size,
  output logic [SINK_WIDTH-1:0]   m1_d_sink,
  output logic [DATA_WIDTH-1:0]   m1_d_data,
  output logic                    m1_d_error,
  output logic                    m1_d_source,
  // downstream A
  output logic                    a_valid_out,
  input  logic                    a_ready_out,
  output logic [OPCODE_WIDTH-1:0] a_opcode_out,
  output logic [PARAM_WIDTH-1:0]  a_param_out,
  output logic [SIZE_WIDTH-1:0]   a_size_out,
  output logic [ADDR_WIDTH-1:0]   a_address_out,
  output logic [MASK_WIDTH-1:0]   a_mask_out,
  output logic [DATA_WIDTH-1:0]   a_data_out,
  output logic [1:0]              a_source_out,
  // downstream D
  input  logic                    d_valid_in,
  output logic                    d_ready_in,
  input  logic [OPCODE_WIDTH-1:0] d_opcode_in,
  input  logic [PARAM_WIDTH-1:0]  d_param_in,
  input  logic [SIZE_WIDTH-1:0]   d_size_in,
  input  logic [SINK_WIDTH-1:0]   d_sink_in,
  input  logic [DATA_WIDTH-1:0]   d_data_in,
  input  logic                    d_error_in,
  input  logic [1:0]              d_source_in,
  // status
  output logic [3:0]              outst0,
  output logic [3:0]              outst1,
  output logic                    err_unexp
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic rr_ptr;
  logic hold;
  logic held;

  logic elig0, elig1;
  logic grant;
  logic a_hs;
  logic d_tgt;
  logic d_unexp;
  logic d_hs0, d_hs1;
  logic up0, up1;

  // A master may compete only while below its outstanding limit
  assign elig0 = m0_a_valid && (outst0 < MAX_CNT);
  assign elig1 = m1_a_valid && (outst1 < MAX_CNT);

  // Grant selection: locked while a beat is stalled, else round-robin
  always_comb begin
    grant = 1'b0;
    if (hold)               grant = held;
    else if (elig0 && elig1) grant = rr_ptr;
    else if (elig1)          grant = 1'b1;
  end

  // A path: combinational mux, outputs gated off while in reset
  always_comb begin
    a_valid_out   = reset && (grant ? elig1 : elig0);
    m0_a_ready    = reset && a_ready_out && !grant && elig0;
    m1_a_ready    = reset && a_ready_out &&  grant && elig1;
    a_opcode_out  = grant ? m1_a_opcode  : m0_a_opcode;
    a_param_out   = grant ? m1_a_param   : m0_a_param;
    a_size_out    = grant ? m1_a_size    : m0_a_size;
    a_address_out = grant ? m1_a_address : m0_a_address;
    a_mask_out    = grant ? m1_a_mask    : m0_a_mask;
    a_data_out    = grant ? m1_a_data    : m0_a_data;
    a_source_out  = {grant, grant ? m1_a_source : m0_a_source};
  end

  assign a_hs = a_valid_out && a_ready_out;
  assign up0  = a_hs && !grant;
  assign up1  = a_hs &&  grant;

  // D path: route by tag; a beat with no matching request is swallowed
  assign d_tgt   = d_source_in[1];
  assign d_unexp = d_tgt ? (outst1 == '0) : (outst0 == '0);

  always_comb begin
    m0_d_valid = reset && d_valid_in && !d_unexp && !d_tgt;
    m1_d_valid = reset && d_valid_in && !d_unexp &&  d_tgt;
    d_ready_in = reset && (d_unexp || (d_tgt ? m1_d_ready : m0_d_ready));
  end

  assign d_hs0 = m0_d_valid && m0_d_ready;
  assign d_hs1 = m1_d_valid && m1_d_ready;

  assign m0_d_opcode = d_opcode_in;
  assign m0_d_param  = d_param_in;
  assign m0_d_size   = d_size_in;
  assign m0_d_sink   = d_sink_in;
  assign m0_d_data   = d_data_in;
  assign m0_d_error  = d_error_in;
  assign m0_d_source = d_source_in[0];
  assign m1_d_opcode = d_opcode_in;
  assign m1_d_param  = d_param_in;
  assign m1_d_size   = d_size_in;
  assign m1_d_sink   = d_sink_in;
  assign m1_d_data   = d_data_in;
  assign m1_d_error  = d_error_in;
  assign m1_d_source = d_source_in[0];

  // Arbitration state, outstanding counters and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= 1'b0;
      hold      <= 1'b0;
      held      <= 1'b0;
      outst0    <= '0;
      outst1    <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (a_hs) begin
        hold   <= 1'b0;
        rr_ptr <= ~grant;
      end else if (a_valid_out) begin
        hold <= 1'b1;
        held <= grant;
      end

      // Increment is only possible below the limit, decrement only above 0
      case ({up0, d_hs0})
        2'b10:   outst0 <= outst0 + CNT_W'(1);
        2'b01:   outst0 <= outst0 - CNT_W'(1);
        default: outst0 <= outst0;
      endcase
      case ({up1, d_hs1})
        2'b10:   outst1 <= outst1 + CNT_W'(1);
        2'b01:   outst1 <= outst1 - CNT_W'(1);
        default: outst1 <= outst1;
      endcase

      if (d_valid_in && d_unexp) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_ul_arb_2m.sv
// Directed bench for tl_ul_arb_2m (default parameters, MAX_OUTST=4).
module tb_tl_ul_arb_2m;

  logic        clk = 1'b0;
  logic        reset;

  logic        m0_a_valid, m0_a_ready, m0_a_source;
  logic [2:0]  m0_a_opcode, m0_a_param, m0_a_size;
  logic [31:0] m0_a_address, m0_a_data;
  logic [3:0]  m0_a_mask;
  logic        m0_d_valid, m0_d_ready, m0_d_error, m0_d_source;
  logic [2:0]  m0_d_opcode, m0_d_param, m0_d_size;
  logic [0:0]  m0_d_sink;
  logic [31:0] m0_d_data;

  logic        m1_a_valid, m1_a_ready, m1_a_source;
  logic [2:0]  m1_a_opcode, m1_a_param, m1_a_size;
  logic [31:0] m1_a_address, m1_a_data;
  logic [3:0]  m1_a_mask;
  logic        m1_d_valid, m1_d_ready, m1_d_error, m1_d_source;
  logic [2:0]  m1_d_opcode, m1_d_param, m1_d_size;
  logic [0:0]  m1_d_sink;
  logic [31:0] m1_d_data;

  logic        a_valid_out, a_ready_out;
  logic [2:0]  a_opcode_out, a_param_out, a_size_out;
  logic [31:0] a_address_out, a_data_out;
  logic [3:0]  a_mask_out;
  logic [1:0]  a_source_out;

  logic        d_valid_in, d_ready_in, d_error_in;
  logic [2:0]  d_opcode_in, d_param_in, d_size_in;
  logic [0:0]  d_sink_in;
  logic [31:0] d_data_in;
  logic [1:0]  d_source_in;

  logic [3:0]  outst0, outst1;
  logic        err_unexp;

  int checks = 0;
  int errors = 0;

  tl_ul_arb_2m dut (
    .clk(clk), .reset(reset),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
    .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_address(m0_a_address),
    .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data), .m0_a_source(m0_a_source),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
    .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_sink(m0_d_sink),
    .m0_d_data(m0_d_data), .m0_d_error(m0_d_error), .m0_d_source(m0_d_source),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
    .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_address(m1_a_address),
    .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data), .m1_a_source(m1_a_source),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
    .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_sink(m1_d_sink),
    .m1_d_data(m1_d_data), .m1_d_error(m1_d_error), .m1_d_source(m1_d_source),
    .a_valid_out(a_valid_out), .a_ready_out(a_ready_out), .a_opcode_out(a_opcode_out),
    .a_param_out(a_param_out), .a_size_out(a_size_out), .a_address_out(a_address_out),
    .a_mask_out(a_mask_out), .a_data_out(a_data_out), .a_source_out(a_source_out),
    .d_valid_in(d_valid_in), .d_ready_in(d_ready_in), .d_opcode_in(d_opcode_in),
    .d_param_in(d_param_in), .d_size_in(d_size_in), .d_sink_in(d_sink_in),
    .d_data_in(d_data_in), .d_error_in(d_error_in), .d_source_in(d_source_in),
    .outst0(outst0), .outst1(outst1), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #12;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    m0_a_valid = 0; m0_a_source = 0; m0_a_opcode = 3'd4; m0_a_param = 0; m0_a_size = 3'd2;
    m0_a_address = 32'h0000_0100; m0_a_mask = 4'hf; m0_a_data = 32'hA0A0_0000;
    m1_a_valid = 0; m1_a_source = 0; m1_a_opcode = 3'd0; m1_a_param = 0; m1_a_size = 3'd2;
    m1_a_address = 32'h0000_0200; m1_a_mask = 4'h3; m1_a_data = 32'hB1B1_1111;
    m0_d_ready = 0; m1_d_ready = 0; a_ready_out = 0;
    d_valid_in = 0; d_opcode_in = 3'd1; d_param_in = 0; d_size_in = 3'd2; d_sink_in = 0;
    d_data_in = 32'hD00D_F00D; d_error_in = 0; d_source_in = 2'b00;

    // Reset values
    do_reset();
    check("rst_outst0", 64'(outst0), 64'd0);
    check("rst_outst1", 64'(outst1), 64'd0);
    check("rst_err", 64'(err_unexp), 64'd0);
    check("rst_a_valid", 64'(a_valid_out), 64'd0);

    // Single master: same-cycle pass-through and source tagging
    m0_a_valid = 1; m0_a_source = 1; a_ready_out = 1;
    #1;
    check("s1_a_valid", 64'(a_valid_out), 64'd1);
    check("s1_a_source", 64'(a_source_out), 64'd1);
    check("s1_m0_ready", 64'(m0_a_ready), 64'd1);
    check("s1_address", 64'(a_address_out), 64'h100);
    tick();
    m0_a_valid = 0; m0_a_source = 0;
    #1;
    check("s1_outst0", 64'(outst0), 64'd1);

    // Both masters contend: strict alternation starting with m0
    do_reset();
    m0_a_valid = 1; m1_a_valid = 1; a_ready_out = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s2_grant", 64'(a_source_out[1]), 64'(i % 2));
      tick();
    end
    m0_a_valid = 0; m1_a_valid = 0;
    #1;
    check("s2_outst0", 64'(outst0), 64'd2);
    check("s2_outst1", 64'(outst1), 64'd2);

    // Stalled m1 beat is held for 3 cycles while m0 waits
    do_reset();
    a_ready_out = 0; m1_a_valid = 1;
    #1;
    check("s3_grant_c1", 64'(a_source_out[1]), 64'd1);
    check("s3_m1_ready_c1", 64'(m1_a_ready), 64'd0);
    tick();
    m0_a_valid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("s3_hold_grant", 64'(a_source_out[1]), 64'd1);
      check("s3_hold_data", 64'(a_data_out), 64'hB1B1_1111);
      check("s3_hold_m0_ready", 64'(m0_a_ready), 64'd0);
      tick();
    end
    a_ready_out = 1;
    #1;
    check("s3_c4_m1_ready", 64'(m1_a_ready), 64'd1);
    check("s3_c4_m0_ready", 64'(m0_a_ready), 64'd0);
    tick();
    m1_a_valid = 0;
    #1;
    check("s3_c5_grant", 64'(a_source_out[1]), 64'd0);
    check("s3_c5_m0_ready", 64'(m0_a_ready), 64'd1);
    tick();
    m0_a_valid = 0;
    #1;
    check("s3_outst0", 64'(outst0), 64'd1);
    check("s3_outst1", 64'(outst1), 64'd1);

    // Outstanding limit on m0, m1 still served, one response reopens m0
    do_reset();
    m0_a_valid = 1; a_ready_out = 1;
    repeat (4) tick();
    check("s4_outst0_full", 64'(outst0), 64'd4);
    m1_a_valid = 1;
    #1;
    check("s4_m0_blocked", 64'(m0_a_ready), 64'd0);
    check("s4_m1_served", 64'(m1_a_ready), 64'd1);
    check("s4_grant_m1", 64'(a_source_out[1]), 64'd1);
    tick();
    m1_a_valid = 0;
    #1;
    check("s4_a_valid_off", 64'(a_valid_out), 64'd0);
    d_valid_in = 1; d_source_in = 2'b00; m0_d_ready = 1;
    #1;
    check("s4_m0_d_valid", 64'(m0_d_valid), 64'd1);
    check("s4_m1_d_valid", 64'(m1_d_valid), 64'd0);
    check("s4_d_ready", 64'(d_ready_in), 64'd1);
    check("s4_d_data_bcast", 64'(m1_d_data), 64'hD00D_F00D);
    tick();
    d_valid_in = 0; m0_d_ready = 0;
    #1;
    check("s4_outst0_dec", 64'(outst0), 64'd3);
    check("s4_outst1", 64'(outst1), 64'd1);
    check("s4_m0_reopened", 64'(m0_a_ready), 64'd1);
    tick();
    m0_a_valid = 0;
    #1;
    check("s4_outst0_refill", 64'(outst0), 64'd4);

    // Unexpected response on m1 is consumed and flagged
    do_reset();
    d_valid_in = 1; d_source_in = 2'b11; m1_d_ready = 0;
    #1;
    check("s5_d_ready", 64'(d_ready_in), 64'd1);
    check("s5_m1_d_valid", 64'(m1_d_valid), 64'd0);
    check("s5_m0_d_valid", 64'(m0_d_valid), 64'd0);
    check("s5_d_source", 64'(m1_d_source), 64'd1);
    tick();
    d_valid_in = 0; d_source_in = 2'b00;
    #1;
    check("s5_err_set", 64'(err_unexp), 64'd1);
    tick();
    check("s5_err_sticky", 64'(err_unexp), 64'd1);

    // Async reset mid-hold with outst0=3
    m0_a_valid = 1; a_ready_out = 1;
    repeat (3) tick();
    m0_a_valid = 0; a_ready_out = 0; m1_a_valid = 1;
    tick();
    #1;
    check("s6_pre_outst0", 64'(outst0), 64'd3);
    check("s6_pre_hold_valid", 64'(a_valid_out), 64'd1);
    reset = 1'b0;
    #1;
    check("s6_rst_a_valid", 64'(a_valid_out), 64'd0);
    check("s6_rst_outst0", 64'(outst0), 64'd0);
    check("s6_rst_err", 64'(err_unexp), 64'd0);
    check("s6_rst_m1_ready", 64'(m1_a_ready), 64'd0);
    check("s6_rst_d_ready", 64'(d_ready_in), 64'd0);
    tick();
    reset = 1'b1;
    m0_a_valid = 1; a_ready_out = 1;
    #1;
    check("s6_post_grant_m0", 64'(a_source_out[1]), 64'd0);
    check("s6_post_m0_ready", 64'(m0_a_ready), 64'd1);
    tick();
    m0_a_valid = 0; m1_a_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
